// File: rtl/vga_sync_gen_if.sv
// Bundle of VGA timing outputs shared between the sync generator and its consumers.
// Latency: none, this is wiring only.
// Backpressure: none, the timing stream is free-running and cannot be stalled.
`timescale 1ns/1ps
interface vga_sync_gen_if;
  logic       pix_en;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       hSync;
  logic       vSync;
  logic       bright;
  logic       frame_start;

  modport master (
    output pix_en, hCount, vCount, hSync, vSync, bright, frame_start
  );

  modport slave (
    input pix_en, hCount, vCount, hSync, vSync, bright, frame_start
  );
endinterface

// File: rtl/vga_sync_gen.sv
// VGA 640x480 timing generator: clock divider, h/v counters, sync/blank decode, frame pulse.
// Latency: counters step one clk after each pix_en; sync/bright zero-latency, or one pixel tick with VGA_SYNC_REG_EN.
// Backpressure: none, free-running; rst_n (async, active-low) aborts the frame and restarts at (0,0).
`timescale 1ns/1ps
module vga_sync_gen #(
  parameter int CLK_DIV = 4,    // input clocks per pixel, 2..16
  parameter int H_TOTAL = 800,  // pixel ticks per line
  parameter int V_TOTAL = 525   // lines per frame
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_sync_gen_if.master vga
);

  // The visible window and sync widths are fixed to the 640x480 mode.
  localparam logic [9:0] H_SYNC_END  = 10'd96;   // hSync low for hCount 0..95
  localparam logic [9:0] V_SYNC_END  = 10'd2;    // vSync low for vCount 0..1
  localparam logic [9:0] H_VIS_FIRST = 10'd144;
  localparam logic [9:0] H_VIS_LAST  = 10'd783;
  localparam logic [9:0] V_VIS_FIRST = 10'd35;
  localparam logic [9:0] V_VIS_LAST  = 10'd514;

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);

  logic [3:0] div_q;
  logic [9:0] h_q;
  logic [9:0] v_q;
  logic       fs_q;
  logic       pix;
  logic       h_wrap;
  logic       v_wrap;
  logic       hs_d;
  logic       vs_d;
  logic       br_d;

  // Using >= for the wrap tests keeps the counters inside their range even
  // if a bad value were ever loaded; in normal operation it equals ==.
  assign pix    = (div_q == DIV_LAST);
  assign h_wrap = (h_q >= H_LAST);
  assign v_wrap = (v_q >= V_LAST);

  // Pixel-rate divider: counts 0..CLK_DIV-1, pix is high on the last count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= 4'd0;
    end else if (pix || (div_q > DIV_LAST)) begin
      div_q <= 4'd0;
    end else begin
      div_q <= div_q + 4'd1;
    end
  end

  // Horizontal counter advances once per pixel tick and wraps at end of line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q <= 10'd0;
    end else if (pix) begin
      h_q <= h_wrap ? 10'd0 : h_q + 10'd1;
    end
  end

  // Vertical counter advances on the last pixel of each line and wraps at end of frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 10'd0;
    end else if (pix && h_wrap) begin
      v_q <= v_wrap ? 10'd0 : v_q + 10'd1;
    end
  end

  // Frame pulse only on a real wrap from the last pixel, so reset never produces one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fs_q <= 1'b0;
    end else begin
      fs_q <= pix && h_wrap && v_wrap;
    end
  end

  // Decode sync and visible-window flags from the current counters.
  always_comb begin
    hs_d = 1'b1;
    vs_d = 1'b1;
    br_d = 1'b0;
    if (h_q < H_SYNC_END) hs_d = 1'b0;
    if (v_q < V_SYNC_END) vs_d = 1'b0;
    if ((h_q >= H_VIS_FIRST) && (h_q <= H_VIS_LAST) &&
        (v_q >= V_VIS_FIRST) && (v_q <= V_VIS_LAST)) begin
      br_d = 1'b1;
    end
  end

`ifdef VGA_SYNC_REG_EN
  logic hs_q;
  logic vs_q;
  logic br_q;

  // Registered outputs sample the pre-update counters on each pixel tick,
  // so they lag the counters by one tick but cannot glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      br_q <= 1'b0;
    end else if (pix) begin
      hs_q <= hs_d;
      vs_q <= vs_d;
      br_q <= br_d;
    end
  end

  assign vga.hSync  = hs_q;
  assign vga.vSync  = vs_q;
  assign vga.bright = br_q;
`else
  // Counters reset to (0,0), which decodes to hSync=vSync=bright=0, so the
  // combinational outputs meet the reset values without extra gating.
  assign vga.hSync  = hs_d;
  assign vga.vSync  = vs_d;
  assign vga.bright = br_d;
`endif

  assign vga.pix_en      = pix;
  assign vga.hCount      = h_q;
  assign vga.vCount      = v_q;
  assign vga.frame_start = fs_q;

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
Parameters:
REQ-001 The block SHALL expose parameter CLK_DIV, default 4: input clocks per pixel; legal values are 2 to 16.
REQ-002 The block SHALL expose parameter H_TOTAL, default 800: pixel ticks per line.
REQ-003 The block SHALL expose parameter V_TOTAL, default 525: lines per frame.

Ports:
REQ-004 Port clk, input, 1 bit: the single system clock (100 MHz board clock). All state SHALL be clocked on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port pix_en, output, 1 bit: a one-clk pulse every CLK_DIV clocks, marking a pixel tick.
REQ-007 Port hCount, output, 10 bits: horizontal pixel counter, range 0..H_TOTAL-1.
REQ-008 Port vCount, output, 10 bits: vertical line counter, range 0..V_TOTAL-1.
REQ-009 Port hSync, output, 1 bit: horizontal sync, active-low.
REQ-010 Port vSync, output, 1 bit: vertical sync, active-low.
REQ-011 Port bright, output, 1 bit: high while (hCount, vCount) is in the visible 640x480 window.
REQ-012 Port frame_start, output, 1 bit: a one-clk pulse when a new frame begins.

Function
REQ-013 The divider SHALL count 0..CLK_DIV-1 and wrap to 0. pix_en SHALL be high in exactly the clk cycle where the divider equals CLK_DIV-1.
REQ-014 hCount SHALL change only on a clk edge where pix_en=1.
  - If hCount=H_TOTAL-1, hCount SHALL wrap to 0.
  - Otherwise hCount SHALL increment by 1.
REQ-015 vCount SHALL change only on a pix_en edge where hCount=H_TOTAL-1.
  - If vCount=V_TOTAL-1, vCount SHALL wrap to 0.
  - Otherwise vCount SHALL increment by 1.
  - Counter updates SHALL never overshoot the wrap points.
REQ-016 hSync SHALL be 0 exactly when hCount is in 0..95, and 1 otherwise.
REQ-017 vSync SHALL be 0 exactly when vCount is in 0..1, and 1 otherwise.
REQ-018 bright SHALL be 1 exactly when hCount is in 144..783 and vCount is in 35..514, and 0 otherwise.
REQ-019 frame_start SHALL be 1 for exactly one clk cycle: the cycle immediately after the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0, 0). It SHALL NOT pulse on the first frame after reset.
REQ-020 All comparisons SHALL be unsigned, 10 bits wide. Counters SHALL never hold a value at or above their TOTAL.

Reset
REQ-021 While rst_n=0, the following SHALL hold, asynchronously and regardless of clk:
  - divider=0, hCount=0, vCount=0
  - pix_en=0, frame_start=0
  - hSync=0, vSync=0, bright=0
REQ-022 Reset asserted mid-line or mid-frame SHALL abort the frame immediately. No partial pulse SHALL follow.
REQ-023 After rst_n deasserts, the first pix_en SHALL occur on the CLK_DIV-th rising clk edge.

Configuration
REQ-024 The block SHALL support macro VGA_SYNC_REG_EN.
  - Defined: hSync, vSync and bright SHALL be registered, updated only on pix_en edges from the pre-update counter values. They therefore lag hCount/vCount by exactly one pixel tick (CLK_DIV clks) and are glitch-free.
  - Undefined: hSync, vSync and bright SHALL be combinational decodes of the current counters, with zero latency.
  - In both cases the reset value of these three outputs SHALL be 0.

Verification
REQ-025 Reset sweep, CLK_DIV=4: release rst_n -> pix_en pulses on clk edges 4, 8, 12, ...; hCount reads 1 after edge 4.
REQ-026 Line wrap: run to hCount=799, vCount=10, then one pix_en -> hCount=0, vCount=11; hSync=0 for exactly 96 pixel ticks per line.
REQ-027 Frame wrap: run to (799, 524) -> next pix_en gives (0, 0) and a single-clk frame_start; the frame period is 420000 pix_en pulses (1680000 clks).
REQ-028 Visible window: count bright=1 pixel ticks over one frame -> 307200. bright=0 at (143, 35), (784, 35), (144, 34) and (144, 515).
REQ-029 Mid-frame reset: assert rst_n=0 at (300, 200) for 3 clks -> all outputs 0 within the same cycle; restart from (0, 0) with no frame_start pulse.
REQ-030 VGA_SYNC_REG_EN defined: hCount transitions 95->96 -> hSync rises one pix_en later than in the undefined build. Every other REQ-025..REQ-029 check SHALL be unchanged apart from this one-tick shift.
